// File: rtl/asic_dpath_pkg.sv
// Shared definitions for the pipelined accelerator datapath: the micro-op
// encoding and a decoder that folds unused encodings onto NOP.
package asic_dpath_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LDI    = 4'd1,
    OP_ADD    = 4'd2,
    OP_ADDI   = 4'd3,
    OP_MUL    = 4'd4,
    OP_SWS    = 4'd5,
    OP_RELU   = 4'd6,
    OP_CMPEQ  = 4'd7,
    OP_MAC    = 4'd8,
    OP_RDACC  = 4'd9,
    OP_CLRACC = 4'd10,
    OP_OUT    = 4'd11
  } op_e;

  // Map a raw 4-bit opcode onto the enum; encodings 12..15 behave as NOP.
  function automatic op_e op_decode(input logic [3:0] raw);
    op_e op;
    case (raw)
      4'd1:    op = OP_LDI;
      4'd2:    op = OP_ADD;
      4'd3:    op = OP_ADDI;
      4'd4:    op = OP_MUL;
      4'd5:    op = OP_SWS;
      4'd6:    op = OP_RELU;
      4'd7:    op = OP_CMPEQ;
      4'd8:    op = OP_MAC;
      4'd9:    op = OP_RDACC;
      4'd10:   op = OP_CLRACC;
      4'd11:   op = OP_OUT;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/asic_alu.sv
// Combinational ALU for the register-writing micro-ops. Produces the
// writeback value and whether the op writes the destination register.
// Side-effect ops (CMPEQ, MAC, CLRACC, OUT) are handled by the top.
module asic_alu
  import asic_dpath_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] acc_lo,
  output logic [DATA_W-1:0] result,
  output logic              we
);

  // Select the writeback value and write-enable for the decoded op.
  always_comb begin
    result = '0;
    we     = 1'b0;
    case (op)
      OP_LDI: begin
        result = imm;
        we     = 1'b1;
      end
      OP_ADD: begin
        result = a + b;
        we     = 1'b1;
      end
      OP_ADDI: begin
        result = a + imm;
        we     = 1'b1;
      end
      OP_MUL: begin
        result = a * b;
        we     = 1'b1;
      end
      OP_SWS: begin
        // Logical shift brings zeros in from above, so a window that runs
        // past the top of the word reads those bits as 0.
        result = (a >> b[SH_W-1:0]) & DATA_W'(8'hFF);
        we     = 1'b1;
      end
      OP_RELU: begin
        if (b[DATA_W-1]) begin
          result = '0;
        end else begin
          result = b;
        end
        we = 1'b1;
      end
      OP_RDACC: begin
        result = acc_lo;
        we     = 1'b1;
      end
      default: begin
        result = '0;
        we     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/asic_dpath_pipe.sv
// Pipelined accelerator datapath: one micro-op per accepted command,
// registered writeback stage with W->X bypass, accumulator, compare flag
// and a back-pressured response port.
module asic_dpath_pipe
  import asic_dpath_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int ACC_W  = 64,
  parameter int RA_W   = $clog2(NREGS),
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_val,
  output logic              cmd_rdy,
  input  logic [3:0]        cmd_op,
  input  logic [RA_W-1:0]   cmd_rd,
  input  logic [RA_W-1:0]   cmd_rs1,
  input  logic [RA_W-1:0]   cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [DATA_W-1:0] resp_data,
  output logic              eq_flag,
  output logic [ACC_W-1:0]  acc_o,
  output logic              busy
);

  typedef struct packed {
    logic              valid;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wstage_t;

  logic [DATA_W-1:0]   rf_r [NREGS];
  wstage_t             w_r;
  logic [ACC_W-1:0]    acc_r;
  logic                eq_r;
  logic                resp_val_r;
  logic [DATA_W-1:0]   resp_data_r;

  op_e                 op_s;
  logic                fire_s;
  logic [DATA_W-1:0]   a_s;
  logic [DATA_W-1:0]   b_s;
  logic [DATA_W-1:0]   alu_res_s;
  logic                alu_we_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]    prod_ext_s;

  assign op_s    = op_decode(cmd_op);
  // Stall only while a response is held and not being taken this cycle.
  assign cmd_rdy = reset & ~(resp_val_r & ~resp_rdy);
  assign fire_s  = cmd_val & cmd_rdy;

  // Operand A: r0 is hard zero, else newest value from W or the file.
  always_comb begin
    a_s = '0;
    if (cmd_rs1 == '0) begin
      a_s = '0;
    end else if (w_r.valid && (w_r.rd == cmd_rs1)) begin
      a_s = w_r.data;
    end else begin
      a_s = rf_r[cmd_rs1];
    end
  end

  // Operand B: same selection as operand A.
  always_comb begin
    b_s = '0;
    if (cmd_rs2 == '0) begin
      b_s = '0;
    end else if (w_r.valid && (w_r.rd == cmd_rs2)) begin
      b_s = w_r.data;
    end else begin
      b_s = rf_r[cmd_rs2];
    end
  end

  // Full-width product feeds MAC; zero-extended or wrapped to ACC_W.
  assign prod_s     = (2*DATA_W)'(a_s) * (2*DATA_W)'(b_s);
  assign prod_ext_s = ACC_W'(prod_s);

  asic_alu #(
    .DATA_W (DATA_W),
    .SH_W   (SH_W)
  ) u_alu (
    .op     (op_s),
    .a      (a_s),
    .b      (b_s),
    .imm    (cmd_imm),
    .acc_lo (acc_r[DATA_W-1:0]),
    .result (alu_res_s),
    .we     (alu_we_s)
  );

  // Writeback stage capture; writes aimed at r0 never enter W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_r <= '0;
    end else if (fire_s && alu_we_s && (cmd_rd != '0)) begin
      w_r.valid <= 1'b1;
      w_r.rd    <= cmd_rd;
      w_r.data  <= alu_res_s;
    end else begin
      w_r.valid <= 1'b0;
    end
  end

  // Register file write from the W stage, one edge after capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= '0;
      end
    end else if (w_r.valid) begin
      rf_r[w_r.rd] <= w_r.data;
    end
  end

  // Accumulator: updated at accept, so a following RDACC sees the new sum.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_r <= '0;
    end else if (fire_s && (op_s == OP_MAC)) begin
      acc_r <= acc_r + prod_ext_s;
    end else if (fire_s && (op_s == OP_CLRACC)) begin
      acc_r <= '0;
    end
  end

  // Compare flag holds the result of the most recent CMPEQ.
  always_ff @(posedge clk) begin
    if (!reset) begin
      eq_r <= 1'b0;
    end else if (fire_s && (op_s == OP_CMPEQ)) begin
      eq_r <= (a_s == b_s);
    end
  end

  // Response register: load on OUT, hold until consumed, data kept stable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_val_r  <= 1'b0;
      resp_data_r <= '0;
    end else if (fire_s && (op_s == OP_OUT)) begin
      resp_val_r  <= 1'b1;
      resp_data_r <= a_s;
    end else if (resp_rdy) begin
      resp_val_r  <= 1'b0;
    end
  end

  assign resp_val  = resp_val_r;
  assign resp_data = resp_data_r;
  assign eq_flag   = eq_r;
  assign acc_o     = acc_r;
  assign busy      = w_r.valid | resp_val_r;

endmodule

// File: tb/tb_asic_dpath_pipe.sv
// Self-checking bench for asic_dpath_pipe: directed table, hand sequences
// for back-pressure and reset, then randomized commands against an
// architectural model (register array, accumulator, response slot).
module tb_asic_dpath_pipe;
  import asic_dpath_pkg::*;

  logic        clk;
  logic        reset;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_rd;
  logic [3:0]  cmd_rs1;
  logic [3:0]  cmd_rs2;
  logic [31:0] cmd_imm;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_data;
  logic        eq_flag;
  logic [63:0] acc_o;
  logic        busy;

  asic_dpath_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_val   (cmd_val),
    .cmd_rdy   (cmd_rdy),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .cmd_imm   (cmd_imm),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_data (resp_data),
    .eq_flag   (eq_flag),
    .acc_o     (acc_o),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Architectural model state
  logic [31:0] m_rf [16];
  logic [63:0] m_acc;
  logic        m_eq;
  logic        m_rv;
  logic [31:0] m_rdata;
  logic        m_wpend;

  typedef enum int {CK_NONE, CK_RESP, CK_ACC, CK_EQ} ck_e;
  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
    ck_e         kind;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input op_e op, input int rd, input int rs1, input int rs2,
                     input logic [31:0] imm, input ck_e kind, input logic [63:0] exp);
    vec_t v;
    v.op = 4'(op); v.rd = 4'(rd); v.rs1 = 4'(rs1); v.rs2 = 4'(rs2);
    v.imm = imm; v.kind = kind; v.exp = exp;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] subword(input logic [31:0] a, input int s);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < 8; k++) begin
      if (s + k < 32) r[k] = a[s + k];
    end
    return r;
  endfunction

  // One clock: drive at negedge, check ready, advance model, check outputs.
  task automatic step(input logic rst, input logic v, input logic [3:0] op,
                      input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                      input logic [31:0] imm, input logic rr);
    logic        exp_rdy, fire, wr;
    logic [31:0] a, b, res;
    @(negedge clk);
    reset = rst; cmd_val = v; cmd_op = op; cmd_rd = rd;
    cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; resp_rdy = rr;
    #1;
    exp_rdy = rst && !(m_rv && !rr);
    chk("cmd_rdy", 64'(cmd_rdy), 64'(exp_rdy));
    fire = v && exp_rdy;
    a = m_rf[rs1];
    b = m_rf[rs2];
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
      m_acc = 64'd0; m_eq = 1'b0; m_rv = 1'b0; m_rdata = 32'd0; m_wpend = 1'b0;
    end else begin
      wr = 1'b0;
      res = 32'd0;
      if (m_rv && rr) m_rv = 1'b0;
      if (fire) begin
        case (op)
          4'd1:  begin res = imm; wr = 1'b1; end
          4'd2:  begin res = a + b; wr = 1'b1; end
          4'd3:  begin res = a + imm; wr = 1'b1; end
          4'd4:  begin res = 32'((64'(a) * 64'(b)) % 64'h1_0000_0000); wr = 1'b1; end
          4'd5:  begin res = subword(a, int'(b % 32)); wr = 1'b1; end
          4'd6:  begin res = ($signed(b) < 0) ? 32'd0 : b; wr = 1'b1; end
          4'd7:  m_eq = (a == b);
          4'd8:  m_acc = m_acc + (64'(a) * 64'(b));
          4'd9:  begin res = m_acc[31:0]; wr = 1'b1; end
          4'd10: m_acc = 64'd0;
          4'd11: begin m_rv = 1'b1; m_rdata = a; end
          default: ;
        endcase
      end
      m_wpend = wr && (rd != 4'd0);
      if (wr && rd != 4'd0) m_rf[rd] = res;
    end
    chk("resp_val", 64'(resp_val), 64'(m_rv));
    chk("resp_data", 64'(resp_data), 64'(m_rdata));
    chk("eq_flag", 64'(eq_flag), 64'(m_eq));
    chk("acc_o", acc_o, m_acc);
    chk("busy", 64'(busy), 64'(m_wpend || m_rv));
  endtask

  task automatic nop(input logic rst, input logic rr);
    step(rst, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0, rr);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; cmd_val = 1'b0; cmd_op = 4'd0; cmd_rd = 4'd0;
    cmd_rs1 = 4'd0; cmd_rs2 = 4'd0; cmd_imm = 32'd0; resp_rdy = 1'b1;
    for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    m_acc = 64'd0; m_eq = 1'b0; m_rv = 1'b0; m_rdata = 32'd0; m_wpend = 1'b0;

    // Reset state
    nop(1'b0, 1'b1);
    nop(1'b0, 1'b1);
    chk("rst_acc", acc_o, 64'd0);
    chk("rst_resp_val", 64'(resp_val), 64'd0);
    nop(1'b1, 1'b1);

    // Directed table, issued back to back with resp_rdy high
    add(OP_LDI,  1, 0, 0, 32'd5, CK_NONE, 64'd0);
    add(OP_ADD,  2, 1, 1, 32'd0, CK_NONE, 64'd0);
    add(OP_OUT,  0, 2, 0, 32'd0, CK_RESP, 64'd10);
    add(OP_LDI,  3, 0, 0, 32'hFFFF_FFFF, CK_NONE, 64'd0);
    add(OP_ADDI, 4, 3, 0, 32'd2, CK_NONE, 64'd0);
    add(OP_OUT,  0, 4, 0, 32'd0, CK_RESP, 64'd1);
    add(OP_LDI,  0, 0, 0, 32'h55, CK_NONE, 64'd0);
    add(OP_OUT,  0, 0, 0, 32'd0, CK_RESP, 64'd0);
    add(OP_LDI,  5, 0, 0, 32'h1234_5678, CK_NONE, 64'd0);
    add(OP_LDI,  6, 0, 0, 32'd12, CK_NONE, 64'd0);
    add(OP_SWS,  7, 5, 6, 32'd0, CK_NONE, 64'd0);
    add(OP_OUT,  0, 7, 0, 32'd0, CK_RESP, 64'h45);
    add(OP_LDI,  6, 0, 0, 32'd28, CK_NONE, 64'd0);
    add(OP_SWS,  7, 5, 6, 32'd0, CK_NONE, 64'd0);
    add(OP_OUT,  0, 7, 0, 32'd0, CK_RESP, 64'h01);
    add(OP_LDI,  9, 0, 0, 32'hFFFF_FFFF, CK_NONE, 64'd0);
    add(OP_LDI,  6, 0, 0, 32'd31, CK_NONE, 64'd0);
    add(OP_SWS,  7, 9, 6, 32'd0, CK_NONE, 64'd0);
    add(OP_OUT,  0, 7, 0, 32'd0, CK_RESP, 64'h01);
    add(OP_LDI,  1, 0, 0, 32'h8000_0000, CK_NONE, 64'd0);
    add(OP_RELU, 2, 0, 1, 32'd0, CK_NONE, 64'd0);
    add(OP_OUT,  0, 2, 0, 32'd0, CK_RESP, 64'd0);
    add(OP_LDI,  1, 0, 0, 32'd7, CK_NONE, 64'd0);
    add(OP_RELU, 2, 0, 1, 32'd0, CK_NONE, 64'd0);
    add(OP_OUT,  0, 2, 0, 32'd0, CK_RESP, 64'd7);
    add(OP_LDI,  10, 0, 0, 32'h0001_0000, CK_NONE, 64'd0);
    add(OP_MAC,  0, 10, 10, 32'd0, CK_NONE, 64'd0);
    add(OP_MAC,  0, 10, 10, 32'd0, CK_NONE, 64'd0);
    add(OP_MAC,  0, 10, 10, 32'd0, CK_ACC, 64'h3_0000_0000);
    add(OP_RDACC, 8, 0, 0, 32'd0, CK_NONE, 64'd0);
    add(OP_OUT,  0, 8, 0, 32'd0, CK_RESP, 64'd0);
    add(OP_CLRACC, 0, 0, 0, 32'd0, CK_ACC, 64'd0);
    add(OP_CMPEQ, 0, 1, 2, 32'd0, CK_EQ, 64'd1);
    add(OP_CMPEQ, 0, 1, 10, 32'd0, CK_EQ, 64'd0);
    add(OP_LDI,  11, 0, 0, 32'h0001_0001, CK_NONE, 64'd0);
    add(OP_MUL,  12, 11, 11, 32'd0, CK_NONE, 64'd0);
    add(OP_OUT,  0, 12, 0, 32'd0, CK_RESP, 64'h0002_0001);
    add(OP_OUT,  0, 11, 0, 32'd0, CK_RESP, 64'h0001_0001);

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, 1'b1, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, 1'b1);
      case (tbl[i].kind)
        CK_RESP: begin
          chk("tbl_resp_val", 64'(resp_val), 64'd1);
          chk("tbl_resp_data", 64'(resp_data), tbl[i].exp);
        end
        CK_ACC:  chk("tbl_acc", acc_o, tbl[i].exp);
        CK_EQ:   chk("tbl_eq", 64'(eq_flag), tbl[i].exp);
        default: ;
      endcase
    end

    // Back-pressure: held response stalls commands, data stays put
    step(1'b1, 1'b1, 4'(OP_LDI), 4'd1, 4'd0, 4'd0, 32'h0000_ABCD, 1'b1);
    step(1'b1, 1'b1, 4'(OP_OUT), 4'd0, 4'd1, 4'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'(OP_LDI), 4'd1, 4'd0, 4'd0, 32'd99, 1'b0);
      chk("bp_cmd_rdy", 64'(cmd_rdy), 64'd0);
      chk("bp_resp_data", 64'(resp_data), 64'hABCD);
    end
    // Consume and accept a new OUT in the same cycle: no bubble
    step(1'b1, 1'b1, 4'(OP_OUT), 4'd0, 4'd12, 4'd0, 32'd0, 1'b1);
    chk("swap_resp_val", 64'(resp_val), 64'd1);
    chk("swap_resp_data", 64'(resp_data), 64'h0002_0001);
    step(1'b1, 1'b1, 4'(OP_OUT), 4'd0, 4'd1, 4'd0, 32'd0, 1'b0);
    nop(1'b1, 1'b0);
    // Reset while a response and a W write are pending
    step(1'b1, 1'b1, 4'(OP_LDI), 4'd3, 4'd0, 4'd0, 32'd77, 1'b0);
    nop(1'b0, 1'b0);
    chk("rst_mid_resp_val", 64'(resp_val), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    nop(1'b1, 1'b0);
    chk("post_rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
    step(1'b1, 1'b1, 4'(OP_OUT), 4'd0, 4'd3, 4'd0, 32'd0, 1'b1);
    chk("post_rst_r3", 64'(resp_data), 64'd0);

    // Randomized commands against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 4))
        0:       imm = 32'd0;
        1:       imm = 32'hFFFF_FFFF;
        2:       imm = 32'($urandom_range(0, 40));
        3:       imm = 32'h8000_0000 | 32'($urandom_range(0, 3));
        default: imm = $urandom;
      endcase
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 4) != 0),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           imm,
           ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
